// File: rtl/pl_reg_skid.sv
// rtl/pl_reg_skid.sv - elastic pipeline register with 2-entry skid buffer
// Optional stall counter enabled by defining PL_REG_SKID_STATS_EN.
module pl_reg_skid #(
    parameter int                 DATA_W      = 32,
    parameter logic [DATA_W-1:0]  RESET_VAL   = '0,
    parameter int                 STALL_CNT_W = 16
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   Flush,
    input  logic                   ValidIn,
    output logic                   ReadyOut,
    input  logic [DATA_W-1:0]      DataIn,
    output logic                   ValidOut,
    input  logic                   ReadyIn,
    output logic [DATA_W-1:0]      DataOut,
    output logic [STALL_CNT_W-1:0] StallCount
);

    typedef enum logic [1:0] {
        EMPTY = 2'd0,
        ONE   = 2'd1,
        TWO   = 2'd2
    } state_t;

    state_t            state;
    logic [DATA_W-1:0] main_q;
    logic [DATA_W-1:0] skid_q;
    logic              in_fire;
    logic              out_fire;

    // ReadyOut depends only on registered state, so upstream never sees a
    // combinational path from ReadyIn.
    assign ReadyOut = !reset && (state != TWO);
    assign ValidOut = (state != EMPTY);
    assign DataOut  = main_q;
    assign in_fire  = ValidIn && ReadyOut;
    assign out_fire = ValidOut && ReadyIn;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state  <= EMPTY;
            main_q <= RESET_VAL;
            skid_q <= RESET_VAL;
        end else if (Flush) begin
            state <= EMPTY;
        end else begin
            case (state)
                EMPTY: begin
                    if (in_fire) begin
                        main_q <= DataIn;
                        state  <= ONE;
                    end
                end
                ONE: begin
                    if (in_fire && out_fire) begin
                        main_q <= DataIn;
                    end else if (in_fire) begin
                        skid_q <= DataIn;
                        state  <= TWO;
                    end else if (out_fire) begin
                        state <= EMPTY;
                    end
                end
                TWO: begin
                    if (out_fire) begin
                        main_q <= skid_q;
                        state  <= ONE;
                    end
                end
                default: state <= EMPTY;
            endcase
        end
    end

`ifdef PL_REG_SKID_STATS_EN
    logic [STALL_CNT_W-1:0] stall_q;

    // Saturating count of edges where a valid bundle was held by downstream.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            stall_q <= '0;
        end else if (ValidOut && !ReadyIn && (stall_q != '1)) begin
            stall_q <= stall_q + STALL_CNT_W'(1);
        end
    end

    assign StallCount = stall_q;
`else
    assign StallCount = '0;
`endif

endmodule

// File: tb/tb_pl_reg_skid.sv
// tb/tb_pl_reg_skid.sv - directed vector bench for pl_reg_skid
module tb_pl_reg_skid;

    localparam int          DW  = 32;
    localparam int          SCW = 4;
    localparam logic [31:0] RV  = 32'h5A5A_0000;

    logic          clk = 1'b0;
    logic          reset;
    logic          Flush;
    logic          ValidIn;
    logic          ReadyOut;
    logic [DW-1:0] DataIn;
    logic          ValidOut;
    logic          ReadyIn;
    logic [DW-1:0] DataOut;
    logic [SCW-1:0] StallCount;

    pl_reg_skid #(
        .DATA_W(DW),
        .RESET_VAL(RV),
        .STALL_CNT_W(SCW)
    ) dut (
        .clk(clk),
        .reset(reset),
        .Flush(Flush),
        .ValidIn(ValidIn),
        .ReadyOut(ReadyOut),
        .DataIn(DataIn),
        .ValidOut(ValidOut),
        .ReadyIn(ReadyIn),
        .DataOut(DataOut),
        .StallCount(StallCount)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic        flush;
        logic        vin;
        logic [31:0] din;
        logic        rin;
        logic        ev;
        logic        er;
        logic [31:0] ed;
    } vec_t;

    vec_t           vecs[$];
    int             checks = 0;
    int             errors = 0;
    logic           model_valid;
    logic [SCW-1:0] model_cnt;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
        end
    endtask

    function automatic void add(input logic f, input logic vi, input logic [31:0] d,
                                input logic ri, input logic ev, input logic er,
                                input logic [31:0] ed);
        vec_t v;
        v.flush = f; v.vin = vi; v.din = d; v.rin = ri;
        v.ev = ev; v.er = er; v.ed = ed;
        vecs.push_back(v);
    endfunction

    task automatic apply(input vec_t v, input string tag);
        logic stall;
        @(negedge clk);
        Flush   = v.flush;
        ValidIn = v.vin;
        DataIn  = v.din;
        ReadyIn = v.rin;
        stall   = model_valid && !v.rin;
        @(posedge clk);
        #1;
`ifdef PL_REG_SKID_STATS_EN
        if (stall && model_cnt != {SCW{1'b1}}) model_cnt = model_cnt + 1'b1;
`endif
        check({tag, " ValidOut"}, {31'd0, ValidOut}, {31'd0, v.ev});
        check({tag, " ReadyOut"}, {31'd0, ReadyOut}, {31'd0, v.er});
        check({tag, " DataOut"}, DataOut, v.ed);
        check({tag, " StallCount"}, {28'd0, StallCount}, {28'd0, model_cnt});
        model_valid = v.ev;
    endtask

    initial begin
        vec_t v;
        reset = 1'b1; Flush = 1'b0; ValidIn = 1'b0; DataIn = '0; ReadyIn = 1'b0;
        model_valid = 1'b0;
        model_cnt   = '0;

        // Streaming at full rate
        for (int i = 1; i <= 8; i++) add(0, 1, i, 1, 1, 1, i);
        add(0, 0, 32'h0, 1, 0, 1, 32'd8);
        // Backpressure fills the skid, data held stable while stalled
        add(0, 1, 32'h10, 0, 1, 1, 32'h10);
        add(0, 1, 32'h11, 0, 1, 0, 32'h10);
        for (int i = 0; i < 5; i++) add(0, 1, 32'h99, 0, 1, 0, 32'h10);
        add(0, 0, 32'h0, 1, 1, 1, 32'h11);
        add(0, 0, 32'h0, 1, 0, 1, 32'h11);
        // Simultaneous push and pop in ONE
        add(0, 1, 32'h30, 0, 1, 1, 32'h30);
        add(0, 1, 32'h31, 1, 1, 1, 32'h31);
        add(0, 0, 32'h0, 1, 0, 1, 32'h31);
        // Flush with simultaneous push drops the push
        add(0, 1, 32'h20, 0, 1, 1, 32'h20);
        add(1, 1, 32'h21, 0, 0, 1, 32'h20);
        add(0, 0, 32'h0, 1, 0, 1, 32'h20);
        // Flush from TWO discards the skid entry
        add(0, 1, 32'h40, 0, 1, 1, 32'h40);
        add(0, 1, 32'h41, 0, 1, 0, 32'h40);
        add(1, 0, 32'h0, 1, 0, 1, 32'h40);
        add(1, 1, 32'h42, 1, 0, 1, 32'h40);
        add(0, 1, 32'h50, 1, 1, 1, 32'h50);
        add(0, 0, 32'h0, 1, 0, 1, 32'h50);

        #1;
        check("reset ValidOut", {31'd0, ValidOut}, 32'd0);
        check("reset ReadyOut", {31'd0, ReadyOut}, 32'd0);
        check("reset DataOut", DataOut, RV);
        check("reset StallCount", {28'd0, StallCount}, 32'd0);
        @(negedge clk);
        reset = 1'b0;
        #1;
        check("post-reset ReadyOut", {31'd0, ReadyOut}, 32'd1);

        foreach (vecs[i]) apply(vecs[i], $sformatf("vec%0d", i));

        // Reset asserted mid-cycle while in TWO
        v = '{0, 1, 32'hAAAA0001, 0, 1, 1, 32'hAAAA0001};
        apply(v, "fill1");
        v = '{0, 1, 32'hAAAA0002, 0, 1, 0, 32'hAAAA0001};
        apply(v, "fill2");
        @(negedge clk);
        ValidIn = 1'b0;
        #2 reset = 1'b1;
        #1;
        check("async ValidOut", {31'd0, ValidOut}, 32'd0);
        check("async ReadyOut", {31'd0, ReadyOut}, 32'd0);
        check("async DataOut", DataOut, RV);
        check("async StallCount", {28'd0, StallCount}, 32'd0);
        model_valid = 1'b0;
        model_cnt   = '0;
        @(negedge clk);
        #3 reset = 1'b0;
        #1;
        check("release ReadyOut", {31'd0, ReadyOut}, 32'd1);
        check("release ValidOut", {31'd0, ValidOut}, 32'd0);

        // Long stall: counter saturates, data held
        v = '{0, 1, 32'h77, 1, 1, 1, 32'h77};
        apply(v, "stats push");
        for (int i = 0; i < 20; i++) begin
            v = '{0, 0, 32'h0, 0, 1, 1, 32'h77};
            apply(v, $sformatf("stall%0d", i));
        end
`ifdef PL_REG_SKID_STATS_EN
        check("sat StallCount", {28'd0, StallCount}, 32'd15);
`else
        check("tied StallCount", {28'd0, StallCount}, 32'd0);
`endif
        v = '{1, 0, 32'h0, 1, 0, 1, 32'h77};
        apply(v, "flush keeps count");
`ifdef PL_REG_SKID_STATS_EN
        check("flush StallCount", {28'd0, StallCount}, 32'd15);
`else
        check("flush StallCount", {28'd0, StallCount}, 32'd0);
`endif

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/pl_reg_skid.md
Name: pl_reg_skid

Overview:
Parametrised elastic pipeline register for the pipelined RISC-V core. It is the successor to the fixed-field stage registers.
- Carries one packed DATA_W-bit stage bundle between two pipeline stages.
- Uses a valid/ready handshake with a 2-entry skid buffer, so the upstream stage sees a registered ready and full throughput is kept under stalls.
- Adds a synchronous flush (bubble insert) and an asynchronous reset.

Parameters:
DATA_W, 32, width of the packed stage bundle (control + data fields), >= 1
RESET_VAL, 0, value loaded into both data registers on reset (DATA_W bits)
STALL_CNT_W, 16, width of the optional stall counter

Ports:
clk  input  1  clock, rising edge
reset  input  1  asynchronous, active-high reset
Flush  input  1  synchronous flush; discards all held entries
ValidIn  input  1  upstream bundle valid
ReadyOut  output  1  this block can accept a bundle
DataIn  input  DATA_W  upstream bundle
ValidOut  output  1  DataOut holds a valid bundle
ReadyIn  input  1  downstream accepts the bundle
DataOut  output  DATA_W  bundle to downstream stage
StallCount  output  STALL_CNT_W  downstream-stall cycle count (optional feature)

Behaviour:
- Clocking and reset: one clock; reset is asynchronous and active-high.
- Handshakes: in_fire = ValidIn & ReadyOut; out_fire = ValidOut & ReadyIn.
- State encoding: EMPTY (no entry), ONE (main reg valid), TWO (main + skid valid).
- Outputs:
  - ValidOut = (state != EMPTY).
  - DataOut = main register; no combinational path from DataIn.
  - ReadyOut = !reset & (state != TWO); it is derived from registered state only.
- Reset (async assert, removal at any time): state <= EMPTY, main <= RESET_VAL, skid <= RESET_VAL, StallCount <= 0. ValidOut=0 and ReadyOut=0 while reset is high.
- Transitions, evaluated at the rising edge when Flush=0:
  - EMPTY: in_fire -> main<=DataIn, ONE; otherwise stay.
  - ONE: in_fire & out_fire -> main<=DataIn, ONE. in_fire only -> skid<=DataIn, TWO. out_fire only -> EMPTY. Neither -> hold.
  - TWO: out_fire -> main<=skid, ONE. ReadyOut=0, so no in_fire is possible.
- Flush:
  - Flush=1 at an edge -> state<=EMPTY regardless of in_fire/out_fire.
  - A simultaneous in_fire is dropped. Upstream must treat it as consumed, because ReadyOut was high.
  - Data registers are not written.
  - ValidOut=0 from the next cycle. Flush held high keeps the block EMPTY.
- Latency and throughput:
  - Latency DataIn -> DataOut is 1 cycle.
  - Sustained throughput is 1 bundle/cycle when ReadyIn is held high.
  - Bundles leave in arrival order; none are duplicated or lost (except on flush/reset).
- Stability: while ValidOut=1 & ReadyIn=0, DataOut and ValidOut hold constant.
- Width: DataIn/DataOut pass through bit-exact; no arithmetic on data.

Optional Feature:
PL_REG_SKID_STATS_EN:
- When defined: StallCount increments by 1 on every edge where ValidOut=1 & ReadyIn=0. It saturates at all-ones and does not wrap. It is cleared only by reset; Flush does not clear it.
- When undefined: the counter logic is absent and StallCount is tied to 0. The port is present in both builds.

Test Plan:
- Reset mid-stream: fill to TWO with 0xAAAA0001, 0xAAAA0002, then assert reset asynchronously mid-cycle -> ValidOut=0 and ReadyOut=0 immediately, DataOut=RESET_VAL. After release, ReadyOut=1 and state EMPTY.
- Streaming: ReadyIn=1, ValidIn=1, DataIn=1,2,3,...,8 on consecutive cycles -> DataOut=1..8 one cycle later, ValidOut high throughout, ReadyOut never drops.
- Backpressure and skid:
  - Push 0x10 and 0x11 with ReadyIn=0 -> after 2 edges ReadyOut=0 and DataOut=0x10, held stable for 5 stalled cycles.
  - Then ReadyIn=1 -> outputs 0x10, then 0x11; ReadyOut returns to 1 one cycle after the first out_fire.
- Flush with simultaneous push: state ONE holding 0x20, Flush=1 and ValidIn=1 with 0x21 in the same cycle -> next cycle ValidOut=0; 0x21 never appears on DataOut.
- Stats (PL_REG_SKID_STATS_EN, STALL_CNT_W=4): hold ValidOut=1, ReadyIn=0 for 20 cycles -> StallCount=15 and stays there. Without the macro -> StallCount=0 throughout.
